// File: rtl/config_pkg.sv
// Shared types and constants for the configuration-port arbiter.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_e;

  localparam int DROP_COUNT_WIDTH = 8;

endpackage

// File: rtl/config_prio_encoder.sv
// Fixed-priority encoder: highest set request index wins.
module config_prio_encoder #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Scan upward so the last (highest) active request overwrites lower ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/config_port_arbiter.sv
// N-source arbiter for the fabric configuration write path. One owner at a
// time, locked until it releases, times out or (optionally) is preempted;
// a dead gap separates owners. Outputs are registered, 1-cycle latency.
module config_port_arbiter
  import config_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int SWITCH_GAP   = 2,
  parameter int PREEMPT      = 0
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            port_active,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
  input  logic [NUM_PORTS-1:0]            port_strobe,
  output logic [DATA_WIDTH-1:0]           ConfigWriteData,
  output logic                            ConfigWriteStrobe,
  output logic                            FSM_Reset,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic [DROP_COUNT_WIDTH-1:0]     drop_count
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int GW = $clog2(SWITCH_GAP + 1);
  // Revoke on the idle cycle that would bring the counter to IDLE_TIMEOUT,
  // so an owner holds grant for exactly IDLE_TIMEOUT strobe-less cycles.
  localparam logic [TW-1:0] TMO_LAST = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'(SWITCH_GAP - 1);
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = '1;

  arb_state_e                  state_q, state_d;
  logic [IW-1:0]               owner_q, owner_d;
  logic [NUM_PORTS-1:0]        grant_q, grant_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        wstb_q, wstb_d;
  logic                        fsm_rst_q, fsm_rst_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;

  logic [NUM_PORTS-1:0] enc_onehot;
  logic [IW-1:0]        enc_idx;
  logic                 enc_any;

  config_prio_encoder #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IW)
  ) u_prio (
    .req    (port_active),
    .onehot (enc_onehot),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  // Next-state, counters and data capture; fwd marks the one source whose
  // strobe is forwarded this cycle, everything else counts as a drop.
  always_comb begin
    logic [NUM_PORTS-1:0] fwd;
    logic [IW-1:0]        sel;
    logic                 capture;
    logic                 owner_stb;
    logic                 tmo_hit;
    logic                 preempt_hit;
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    wdata_d     = wdata_q;
    wstb_d      = 1'b0;
    fsm_rst_d   = 1'b0;
    drop_d      = drop_q;
    fwd         = '0;
    sel         = owner_q;
    capture     = 1'b0;
    owner_stb   = port_strobe[owner_q];
    tmo_hit     = 1'b0;
    preempt_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d   = GRANT;
          owner_d   = enc_idx;
          grant_d   = enc_onehot;
          fsm_rst_d = 1'b1;
          tmo_d     = '0;
          fwd       = enc_onehot;
          sel       = enc_idx;
          capture   = 1'b1;
        end
      end
      GRANT: begin
        fwd     = grant_q;
        capture = 1'b1;
        if (owner_stb)              tmo_d = '0;
        else if (IDLE_TIMEOUT > 0)  tmo_d = tmo_q + TW'(1);
        tmo_hit     = (IDLE_TIMEOUT > 0) && !owner_stb && (tmo_q == TMO_LAST);
        preempt_hit = (PREEMPT != 0) && enc_any && (enc_idx > owner_q);
        if (!port_active[owner_q] || tmo_hit || preempt_hit) begin
          state_d = GAP;
          grant_d = '0;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      wstb_d = port_strobe[sel];
      if (wstb_d) wdata_d = port_data[sel*DATA_WIDTH +: DATA_WIDTH];
    end
    if (|(port_strobe & ~fwd) && (drop_q != DROP_MAX)) drop_d = drop_q + 1'b1;
  end

  // State and output registers; reset drops any current owner at once.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      grant_q   <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      wdata_q   <= '0;
      wstb_q    <= 1'b0;
      fsm_rst_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      wdata_q   <= wdata_d;
      wstb_q    <= wstb_d;
      fsm_rst_q <= fsm_rst_d;
      drop_q    <= drop_d;
    end
  end

  assign ConfigWriteData   = wdata_q;
  assign ConfigWriteStrobe = wstb_q;
  assign FSM_Reset         = fsm_rst_q;
  assign grant             = grant_q;
  assign busy              = |grant_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench: dut_a (no preempt, 16-cycle timeout) and dut_p (preempt,
// no timeout) share the same source inputs.
module tb_config_port_arbiter;

  logic         CLK = 1'b0;
  logic         reset;
  logic [3:0]   act;
  logic [127:0] dat;
  logic [3:0]   stb;

  logic [31:0] a_data, p_data;
  logic        a_stb, a_frst, a_busy, p_stb, p_frst, p_busy;
  logic [3:0]  a_grant, p_grant;
  logic [7:0]  a_drop, p_drop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  config_port_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(32), .IDLE_TIMEOUT(16), .SWITCH_GAP(2), .PREEMPT(0)
  ) dut_a (
    .CLK(CLK), .reset(reset), .port_active(act), .port_data(dat), .port_strobe(stb),
    .ConfigWriteData(a_data), .ConfigWriteStrobe(a_stb), .FSM_Reset(a_frst),
    .grant(a_grant), .busy(a_busy), .drop_count(a_drop)
  );

  config_port_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(32), .IDLE_TIMEOUT(0), .SWITCH_GAP(2), .PREEMPT(1)
  ) dut_p (
    .CLK(CLK), .reset(reset), .port_active(act), .port_data(dat), .port_strobe(stb),
    .ConfigWriteData(p_data), .ConfigWriteStrobe(p_stb), .FSM_Reset(p_frst),
    .grant(p_grant), .busy(p_busy), .drop_count(p_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; act = '0; stb = '0; dat = '0;
    step(); step();
    chk("rst_grant", a_grant, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_stb",   a_stb, 0);
    chk("rst_data",  a_data, 0);
    chk("rst_frst",  a_frst, 0);
    chk("rst_drop",  a_drop, 0);
    reset = 1'b0;

    // 1: single source, three strobes
    act = 4'b0001;
    step();
    chk("t1_grant", a_grant, 4'b0001);
    chk("t1_frst",  a_frst, 1);
    chk("t1_busy",  a_busy, 1);
    step();
    chk("t1_frst_pulse", a_frst, 0);
    for (int k = 1; k <= 3; k++) begin
      stb = 4'b0001; dat[31:0] = 32'hA5A5_0000 + k;
      step();
      chk("t1_stb",  a_stb, 1);
      chk("t1_data", a_data, 32'hA5A5_0000 + k);
      stb = '0;
      step();
      chk("t1_stb_off", a_stb, 0);
      chk("t1_hold",    a_data, 32'hA5A5_0000 + k);
    end
    chk("t1_drop", a_drop, 0);
    act = '0;
    repeat (4) step();
    chk("t1_release", a_grant, 0);

    // 2: contention without preemption
    act = 4'b0001;
    step();
    chk("t2_grant0", a_grant, 4'b0001);
    act = 4'b1001;
    step();
    chk("t2_keep", a_grant, 4'b0001);
    stb = 4'b1000; dat[127:96] = 32'hDEAD_0003;
    step();
    chk("t2_drop1", a_drop, 1);
    chk("t2_nofwd", a_stb, 0);
    stb = '0; step();
    stb = 4'b1000; step();
    chk("t2_drop2", a_drop, 2);
    // owner strobe in the cycle its active drops is still forwarded
    act = 4'b1000; stb = 4'b0001; dat[31:0] = 32'h0000_BEEF;
    step();
    chk("t2_last_stb",  a_stb, 1);
    chk("t2_last_data", a_data, 32'h0000_BEEF);
    chk("t2_gap0",      a_grant, 0);
    chk("t2_drop_same", a_drop, 2);
    stb = 4'b0001;
    step();
    chk("t2_gap1",     a_grant, 0);
    chk("t2_gap_drop", a_drop, 3);
    chk("t2_gap_nofw", a_stb, 0);
    stb = '0;
    step();
    chk("t2_idle", a_grant, 0);
    step();
    chk("t2_grant3", a_grant, 4'b1000);
    chk("t2_frst3",  a_frst, 1);
    act = '0;
    repeat (4) step();

    // 4: timeout revocation and re-grant
    act = 4'b0001;
    step();
    n = 0;
    for (int i = 0; i < 40 && a_grant == 4'b0001; i++) begin n++; step(); end
    chk("t4_hold_cycles", n, 16);
    n = 0;
    for (int i = 0; i < 20 && a_grant == 4'b0000; i++) begin n++; step(); end
    chk("t4_dead_cycles", n, 3);
    chk("t4_regrant", a_grant, 4'b0001);
    chk("t4_refrst",  a_frst, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      stb = (i % 10 == 9) ? 4'b0001 : 4'b0000;
      step();
      if (a_grant == 4'b0001) n++;
    end
    stb = '0;
    chk("t4_kept", n, 60);
    act = '0;
    repeat (4) step();

    // 3: preemption on dut_p (dut_a must keep its owner)
    reset = 1'b1; step(); reset = 1'b0;
    act = 4'b0010;
    step();
    chk("t3_grant1", p_grant, 4'b0010);
    step();
    act = 4'b0110;
    step();
    n = 0;
    for (int i = 0; i < 20 && p_grant == 4'b0000; i++) begin n++; step(); end
    chk("t3_dead_cycles", n, 3);
    chk("t3_grant2",  p_grant, 4'b0100);
    chk("t3_frst",    p_frst, 1);
    chk("t3_nopre_a", a_grant, 4'b0010);

    // 5: reset mid-session with a strobe pending
    stb = 4'b0010; dat[63:32] = 32'h1234_5678; reset = 1'b1;
    step();
    chk("t5_stb",   a_stb, 0);
    chk("t5_grant", a_grant, 0);
    chk("t5_busy",  a_busy, 0);
    chk("t5_data",  a_data, 0);
    chk("t5_frst",  a_frst, 0);
    chk("t5_pgrant", p_grant, 0);
    reset = 1'b0; act = '0; stb = '0;
    step();

    // 6: drop counter saturation
    stb = 4'b0001;
    repeat (100) step();
    chk("t6_drop100", a_drop, 100);
    repeat (200) step();
    chk("t6_sat", a_drop, 255);
    repeat (5) step();
    chk("t6_sat_hold", a_drop, 255);
    chk("t6_nostb", a_stb, 0);
    stb = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
